// File: rtl/timer_peripheral.sv
// Memory-mapped interval timer with prescaler, overflow reload and level IRQ,
// plus a free-running 32-bit SYSTICK cycle counter on the MEM-stage data bus.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [15:0] PRESCALE  = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_control_read,
    input  logic        i_control_write,
    input  logic [31:0] i_control_write_data,
    output logic [31:0] o_control_read_data,
    output logic        o_hit,
    output logic        o_irq
);

    localparam logic [31:0] ADDR_TH      = BASE_ADDR;
    localparam logic [31:0] ADDR_TL      = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_TCON    = BASE_ADDR + 32'd8;
    localparam logic [31:0] ADDR_SYSTICK = BASE_ADDR + 32'd24;
    localparam logic [15:0] PCNT_LAST    = PRESCALE - 16'd1;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [15:0] pcnt;
    logic [31:0] systick;

    logic hit_th, hit_tl, hit_tcon, hit_systick;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, tl_at_max, overflow, set_status;

    // Exact 32-bit compare: misaligned or unmapped window addresses never hit.
    assign hit_th      = (i_address == ADDR_TH);
    assign hit_tl      = (i_address == ADDR_TL);
    assign hit_tcon    = (i_address == ADDR_TCON);
    assign hit_systick = (i_address == ADDR_SYSTICK);
    assign o_hit       = hit_th | hit_tl | hit_tcon | hit_systick;

    assign wr_th   = i_control_write & hit_th;
    assign wr_tl   = i_control_write & hit_tl;
    assign wr_tcon = i_control_write & hit_tcon;

    assign tick       = tcon[0] & (pcnt == PCNT_LAST);
    assign tl_at_max  = &tl;
    // A store to TL on the same edge pre-empts the tick, so no reload happens.
    assign overflow   = tick & tl_at_max & ~wr_tl;
    assign set_status = overflow & tcon[1];

    assign o_irq = tcon[1] & tcon[2];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes the collision rules hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (wr_tl || wr_tcon || tick) begin
            pcnt <= '0;
        end else if (tcon[0]) begin
            pcnt <= pcnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
        end else if (wr_th) begin
            th <= i_control_write_data;
        end
    end

    // Reload uses the pre-edge TH, so a concurrent TH store only affects the next reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= '0;
        end else if (wr_tl) begin
            tl <= i_control_write_data;
        end else if (tick) begin
            tl <= tl_at_max ? th : tl + 32'd1;
        end
    end

    // Overflow status set beats a software clear on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
        end else if (wr_tcon) begin
            tcon <= {i_control_write_data[2] | set_status, i_control_write_data[1:0]};
        end else if (set_status) begin
            tcon[2] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    // NOTE: the default at the top of the block keeps this mux free of latches.
    always_comb begin
        o_control_read_data = '0;
        if (i_control_read) begin
            unique case (1'b1)
                hit_th:      o_control_read_data = th;
                hit_tl:      o_control_read_data = tl;
                hit_tcon:    o_control_read_data = {29'b0, tcon};
                hit_systick: o_control_read_data = systick;
                default:     o_control_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_peripheral.sv
// Bench for timer_peripheral: two instances (PRESCALE 1 and 4) on one bus,
// checked against a register-level reference model built from the timer rules.
module tb_timer_peripheral;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_ST   = 32'h4000_0018;

    typedef struct packed {
        logic [31:0] th;
        logic [31:0] tl;
        logic [2:0]  tcon;
        logic [15:0] pcnt;
        logic [31:0] systick;
    } model_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata4;
    logic        hit1, hit4, irq1, irq4;

    int checks = 0;
    int failures = 0;

    model_t m1, m4;

    always #5 clk = ~clk;

    timer_peripheral #(.BASE_ADDR(A_TH), .PRESCALE(16'd1)) dut1 (
        .clk(clk), .reset(reset), .i_address(address), .i_control_read(rd_en),
        .i_control_write(wr_en), .i_control_write_data(wdata),
        .o_control_read_data(rdata1), .o_hit(hit1), .o_irq(irq1)
    );

    timer_peripheral #(.BASE_ADDR(A_TH), .PRESCALE(16'd4)) dut4 (
        .clk(clk), .reset(reset), .i_address(address), .i_control_read(rd_en),
        .i_control_write(wr_en), .i_control_write_data(wdata),
        .o_control_read_data(rdata4), .o_hit(hit4), .o_irq(irq4)
    );

    // Register-level reference: one call applies every rule for one clock edge.
    function automatic model_t model_next(model_t m, int presc, logic [31:0] a,
                                          logic we, logic [31:0] d);
        model_t n = m;
        logic wth, wtl, wtc, tick, ovf;
        wth  = we && (a == A_TH);
        wtl  = we && (a == A_TL);
        wtc  = we && (a == A_TCON);
        tick = m.tcon[0] && (int'(m.pcnt) == presc - 1);
        ovf  = tick && !wtl && (m.tl == 32'hFFFF_FFFF);
        n.systick = m.systick + 1;
        if (wtl) n.tl = d;
        else if (tick) n.tl = (m.tl == 32'hFFFF_FFFF) ? m.th : m.tl + 1;
        if (wth) n.th = d;
        if (wtc) n.tcon = d[2:0];
        if (ovf && m.tcon[1]) n.tcon[2] = 1'b1;
        if (wtl || wtc || tick) n.pcnt = 0;
        else if (m.tcon[0]) n.pcnt = m.pcnt + 1;
        return n;
    endfunction

    function automatic logic [31:0] model_read(model_t m, logic [31:0] a);
        case (a)
            A_TH:    return m.th;
            A_TL:    return m.tl;
            A_TCON:  return {29'b0, m.tcon};
            A_ST:    return m.systick;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic is_reg(logic [31:0] a);
        return (a == A_TH) || (a == A_TL) || (a == A_TCON) || (a == A_ST);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m1 <= '0;
            m4 <= '0;
        end else begin
            m1 <= model_next(m1, 1, address, wr_en, wdata);
            m4 <= model_next(m4, 4, address, wr_en, wdata);
        end
    end

    // Bus helpers: every task starts and ends just after a falling edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        address = a; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sample(input logic [31:0] a);
        address = a; rd_en = 1'b1; wr_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4];
        addrs = '{A_TH, A_TL, A_TCON, A_ST};
        reset = 1'b0;
        repeat (6) begin
            address = addrs[$urandom_range(0, 3)];
            wdata = $urandom; wr_en = 1'($urandom); rd_en = 1'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(addrs[i]);
            checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_read1[%0d] got=%h exp=0", i, rdata1); end
            checks++; if (rdata4 !== 32'h0) begin failures++; $display("FAIL reset_read4[%0d] got=%h exp=0", i, rdata4); end
        end
        checks++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b%b exp=00", irq1, irq4); end
        rd_en = 1'b0;
    endtask

    task automatic test_overflow();
        do_write(A_TCON, 32'h0);
        do_write(A_TH, 32'hFFFF_FFFD);
        do_write(A_TL, 32'hFFFF_FFFE);
        do_write(A_TCON, 32'h3);
        idle(1);
        sample(A_TL);
        checks++; if (rdata1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ovf_tl_max got=%h exp=ffffffff", rdata1); end
        rd_en = 1'b0;
        idle(1);
        sample(A_TL);
        checks++; if (rdata1 !== 32'hFFFF_FFFD) begin failures++; $display("FAIL ovf_reload got=%h exp=fffffffd", rdata1); end
        sample(A_TCON);
        checks++; if (rdata1 !== 32'h7) begin failures++; $display("FAIL ovf_tcon got=%h exp=7", rdata1); end
        checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL ovf_irq_set got=%b exp=1", irq1); end
        rd_en = 1'b0;
        do_write(A_TCON, 32'h3);
        #1;
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL ovf_irq_clear got=%b exp=0", irq1); end
        sample(A_TL);
        checks++; if (rdata1 !== model_read(m1, A_TL)) begin failures++; $display("FAIL ovf_tl_after got=%h exp=%h", rdata1, model_read(m1, A_TL)); end
        rd_en = 1'b0;
    endtask

    task automatic test_prescaler();
        do_write(A_TCON, 32'h0);
        do_write(A_TL, 32'h0);
        do_write(A_TCON, 32'h1);
        idle(3);
        sample(A_TL);
        checks++; if (rdata4 !== 32'd0) begin failures++; $display("FAIL presc_before_tick got=%h exp=0", rdata4); end
        rd_en = 1'b0;
        idle(1);
        sample(A_TL);
        checks++; if (rdata4 !== 32'd1) begin failures++; $display("FAIL presc_4_cycles got=%h exp=1", rdata4); end
        rd_en = 1'b0;
        idle(8);
        sample(A_TL);
        checks++; if (rdata4 !== 32'd3) begin failures++; $display("FAIL presc_12_cycles got=%h exp=3", rdata4); end
        rd_en = 1'b0;
        do_write(A_TCON, 32'h0);
        idle(10);
        sample(A_TL);
        checks++; if (rdata4 !== 32'd3) begin failures++; $display("FAIL presc_frozen got=%h exp=3", rdata4); end
        checks++; if (rdata1 !== model_read(m1, A_TL)) begin failures++; $display("FAIL presc_dut1_tl got=%h exp=%h", rdata1, model_read(m1, A_TL)); end
        rd_en = 1'b0;
    endtask

    task automatic test_collisions();
        do_write(A_TCON, 32'h1);
        idle(2);
        do_write(A_TL, 32'd5);
        sample(A_TL);
        checks++; if (rdata1 !== 32'd5) begin failures++; $display("FAIL coll_tl_store got=%h exp=5", rdata1); end
        rd_en = 1'b0;
        do_write(A_TCON, 32'h0);
        do_write(A_TH, 32'h100);
        do_write(A_TL, 32'hFFFF_FFFE);
        do_write(A_TCON, 32'h3);
        idle(1);
        do_write(A_TCON, 32'h3);
        sample(A_TCON);
        checks++; if (rdata1 !== 32'h7) begin failures++; $display("FAIL coll_tcon_set_wins got=%h exp=7", rdata1); end
        sample(A_TL);
        checks++; if (rdata1 !== 32'h100) begin failures++; $display("FAIL coll_tcon_reload got=%h exp=100", rdata1); end
        rd_en = 1'b0;
        do_write(A_TL, 32'hFFFF_FFFE);
        idle(1);
        do_write(A_TH, 32'd10);
        sample(A_TL);
        checks++; if (rdata1 !== 32'h100) begin failures++; $display("FAIL coll_th_old_reload got=%h exp=100", rdata1); end
        sample(A_TH);
        checks++; if (rdata1 !== 32'd10) begin failures++; $display("FAIL coll_th_new got=%h exp=a", rdata1); end
        checks++; if (rdata4 !== model_read(m4, A_TH)) begin failures++; $display("FAIL coll_dut4_th got=%h exp=%h", rdata4, model_read(m4, A_TH)); end
        rd_en = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] bad [3];
        logic [31:0] snap_th, snap_tl, snap_tcon, st0;
        bad = '{32'h4000_0001, 32'h4000_000C, 32'h4000_001C};
        do_write(A_TCON, 32'h0);
        snap_th = m1.th; snap_tl = m1.tl; snap_tcon = {29'b0, m1.tcon};
        for (int i = 0; i < 3; i++) begin
            address = bad[i]; rd_en = 1'b1; wr_en = 1'b1; wdata = $urandom;
            #1;
            checks++; if (hit1 !== 1'b0 || hit4 !== 1'b0) begin failures++; $display("FAIL decode_hit[%0d] got=%b%b exp=00", i, hit1, hit4); end
            checks++; if (rdata1 !== 32'h0 || rdata4 !== 32'h0) begin failures++; $display("FAIL decode_read[%0d] got=%h/%h exp=0", i, rdata1, rdata4); end
            @(negedge clk);
            wr_en = 1'b0;
        end
        sample(A_TH);
        checks++; if (hit1 !== 1'b1) begin failures++; $display("FAIL decode_hit_th got=%b exp=1", hit1); end
        checks++; if (rdata1 !== snap_th) begin failures++; $display("FAIL decode_th_kept got=%h exp=%h", rdata1, snap_th); end
        sample(A_TL);
        checks++; if (rdata1 !== snap_tl) begin failures++; $display("FAIL decode_tl_kept got=%h exp=%h", rdata1, snap_tl); end
        sample(A_TCON);
        checks++; if (rdata1 !== snap_tcon) begin failures++; $display("FAIL decode_tcon_kept got=%h exp=%h", rdata1, snap_tcon); end
        sample(A_ST);
        st0 = rdata1;
        checks++; if (st0 !== m1.systick) begin failures++; $display("FAIL decode_systick got=%h exp=%h", st0, m1.systick); end
        do_write(A_ST, 32'hDEAD_BEEF);
        sample(A_ST);
        checks++; if (rdata1 !== st0 + 32'd1) begin failures++; $display("FAIL systick_write_ignored got=%h exp=%h", rdata1, st0 + 32'd1); end
        checks++; if (rdata4 !== st0 + 32'd1) begin failures++; $display("FAIL systick_dut4 got=%h exp=%h", rdata4, st0 + 32'd1); end
        rd_en = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] addrs [8];
        logic [31:0] e1, e4;
        int bad_rd = 0, bad_hit = 0, bad_irq = 0;
        addrs = '{A_TH, A_TL, A_TCON, A_ST, 32'h4000_0002, 32'h4000_000C,
                  32'h4000_0010, 32'h4000_001C};
        for (int i = 0; i < 600; i++) begin
            address = addrs[($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7)];
            rd_en = 1'($urandom);
            wr_en = ($urandom_range(0, 3) == 0);
            case (address)
                A_TL:    wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
                A_TH:    wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
                A_TCON:  wdata = {$urandom_range(0, 1) == 0 ? 29'h0 : 29'(($urandom)), 3'($urandom)};
                default: wdata = $urandom;
            endcase
            #1;
            e1 = rd_en ? model_read(m1, address) : 32'h0;
            e4 = rd_en ? model_read(m4, address) : 32'h0;
            checks++; if (rdata1 !== e1 || rdata4 !== e4) begin
                failures++; bad_rd++;
                if (bad_rd < 5) $display("FAIL rand_read[%0d] addr=%h got=%h/%h exp=%h/%h", i, address, rdata1, rdata4, e1, e4);
            end
            checks++; if (hit1 !== is_reg(address) || hit4 !== is_reg(address)) begin
                failures++; bad_hit++;
                if (bad_hit < 5) $display("FAIL rand_hit[%0d] addr=%h got=%b%b exp=%b", i, address, hit1, hit4, is_reg(address));
            end
            checks++; if (irq1 !== (m1.tcon[1] & m1.tcon[2]) || irq4 !== (m4.tcon[1] & m4.tcon[2])) begin
                failures++; bad_irq++;
                if (bad_irq < 5) $display("FAIL rand_irq[%0d] got=%b%b exp=%b%b", i, irq1, irq4, m1.tcon[1] & m1.tcon[2], m4.tcon[1] & m4.tcon[2]);
            end
            @(negedge clk);
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_midcount_reset();
        do_write(A_TCON, 32'h0);
        do_write(A_TL, 32'd1234);
        do_write(A_TCON, 32'h7);
        sample(A_TL);
        checks++; if (rdata1 !== 32'd1234 || irq1 !== 1'b1) begin failures++; $display("FAIL midreset_setup got=%h irq=%b exp=4d2 irq=1", rdata1, irq1); end
        #1 reset = 1'b0;
        #1;
        checks++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b%b exp=00", irq1, irq4); end
        checks++; if (rdata1 !== 32'h0 || rdata4 !== 32'h0) begin failures++; $display("FAIL midreset_tl got=%h/%h exp=0", rdata1, rdata4); end
        checks++; if (hit1 !== 1'b1) begin failures++; $display("FAIL midreset_hit got=%b exp=1", hit1); end
        rd_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sample(A_ST);
        checks++; if (rdata1 !== 32'h0) begin failures++; $display("FAIL midreset_systick got=%h exp=0", rdata1); end
        rd_en = 1'b0;
        idle(3);
        sample(A_ST);
        checks++; if (rdata1 !== 32'd3) begin failures++; $display("FAIL systick_count got=%h exp=3", rdata1); end
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; address = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
        @(negedge clk);
        test_reset();
        test_overflow();
        test_prescaler();
        test_collisions();
        test_decode();
        test_random();
        test_midcount_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
